// File: rtl/cla_pipe_addsub.sv
// Pipelined WIDTH-bit carry-lookahead add/sub built from 4-bit groups; the inter-slice carry is registered.
// Latency STAGES cycles, one op/cycle; a stage loads when it is empty or its successor advances.
// Stalls propagate back to in_ready. Optional CLA_PIPE_SAT_EN makes out_sum saturate on signed overflow.
module cla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int GROUPS = WIDTH / 4;
    localparam int GPS    = GROUPS / STAGES;

    // Returns {carry out, carry into bit 3, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a | b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], c[3], a ^ b ^ c[3:0]};
    endfunction

    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [WIDTH-1:0]  nsum  [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] nc;
    logic [STAGES-1:0] ncm;
    logic [STAGES-1:0] mv;
    logic [WIDTH-1:0]  fin_sum;
    logic              fin_ovf;

    // Stage 0 takes the ports (B pre-inverted for subtract); later stages take the previous registers.
    always_comb begin
        src_a[0] = in_a;
        src_b[0] = in_sub ? ~in_b : in_b;
        src_s[0] = '0;
        src_c[0] = in_sub | in_cin;
        src_v[0] = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            src_a[s] = a_q[s-1];
            src_b[s] = b_q[s-1];
            src_s[s] = sum_q[s-1];
            src_c[s] = c_q[s-1];
            src_v[s] = v_q[s-1];
        end
    end

    always_comb begin : slice_logic
        logic       c;
        logic [5:0] r;
        int         base;
        c    = 1'b0;
        r    = '0;
        base = 0;
        for (int s = 0; s < STAGES; s++) begin
            c        = src_c[s];
            nsum[s]  = src_s[s];
            ncm[s]   = 1'b0;
            for (int g = 0; g < GPS; g++) begin
                base                = 4 * (s * GPS + g);
                r                   = cla4(src_a[s][base+:4], src_b[s][base+:4], c);
                nsum[s][base+:4]    = r[3:0];
                ncm[s]              = r[4];
                c                   = r[5];
            end
            nc[s] = c;
        end
    end

    always_comb begin
        fin_ovf = nc[STAGES-1] ^ ncm[STAGES-1];
        fin_sum = nsum[STAGES-1];
`ifdef CLA_PIPE_SAT_EN
        if (fin_ovf) begin
            fin_sum = src_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Advance chain runs back from the output so bubbles collapse.
    always_comb begin
        mv[STAGES-1] = out_ready | ~v_q[STAGES-1];
        for (int s = STAGES - 2; s >= 0; s--) begin
            mv[s] = ~v_q[s] | mv[s+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (mv[s]) begin
                    v_q[s]   <= src_v[s];
                    a_q[s]   <= src_a[s];
                    b_q[s]   <= src_b[s];
                    c_q[s]   <= nc[s];
                    sum_q[s] <= (s == STAGES - 1) ? fin_sum : nsum[s];
                end
            end
            if (mv[STAGES-1]) begin
                ovf_q  <= fin_ovf;
                zero_q <= ~|fin_sum;
            end
        end
    end

    assign in_ready  = mv[0];
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed plus random bench for cla_pipe_addsub against an arithmetic reference model and scoreboard.
module tb_cla_pipe_addsub;
    localparam int W  = 16;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           t;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           n_acc = 0;
    int           n_emit = 0;
    logic         chk_lat;
    logic         held;
    logic [W+2:0] snap;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        logic [W-1:0] bb;
        logic [W:0]   full;
        exp_t         e;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + ((sub || cin) ? (W+1)'(1) : (W+1)'(0));
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
`ifdef CLA_PIPE_SAT_EN
        if (e.ovf) e.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.zero = (e.sum == '0);
        e.t    = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, settle, score the output and input handshakes, then step past the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin, input logic ordy);
        exp_t e;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_cin    = cin;
        out_ready = ordy;
        #1;
        if (out_valid && !out_ready) begin
            if (held) chk("hold_stable", 32'({out_sum, out_cout, out_ovf, out_zero}), 32'(snap));
            held = 1'b1;
            snap = {out_sum, out_cout, out_ovf, out_zero};
        end else begin
            held = 1'b0;
        end
        if (out_valid && out_ready) begin
            n_emit++;
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'(0));
            end else begin
                e = q.pop_front();
                chk("sum", 32'(out_sum), 32'(e.sum));
                chk("flags", 32'({out_cout, out_ovf, out_zero}), 32'({e.cout, e.ovf, e.zero}));
                if (chk_lat) chk("latency", 32'(cyc - e.t), 32'(ST));
            end
        end
        if (iv && in_ready) begin
            n_acc++;
            e   = model(a, b, sub, cin);
            e.t = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    task automatic rnd_op(input logic ordy);
        cycle(1'b1, W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ordy);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin,
                            input logic [W-1:0] xs, input logic [2:0] xf);
        chk_lat = 1'b1;
        cycle(1'b1, a, b, sub, cin, 1'b1);
        for (int i = 1; i < ST; i++) begin
            chk({tag, "_early"}, 32'(out_valid), 32'(0));
            idle(1'b1);
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'(1));
        chk({tag, "_sum"}, 32'(out_sum), 32'(xs));
        chk({tag, "_flags"}, 32'({out_cout, out_ovf, out_zero}), 32'(xf));
        idle(1'b1);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        chk_lat   = 1'b0;
        held      = 1'b0;
        snap      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(out_sum), 32'(0));
        chk("rst_flags", 32'({out_cout, out_ovf, out_zero}), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

`ifdef CLA_PIPE_SAT_EN
        directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 3'b010);
        directed("neg_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 3'b110);
`else
        directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 3'b010);
        directed("neg_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 3'b110);
`endif
        directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 3'b101);
        directed("borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 3'b000);
        directed("cin_add", 16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 3'b000);
        directed("sub_ign_cin", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 3'b101);

        // Back-to-back stream with no backpressure.
        chk_lat = 1'b1;
        base    = n_emit;
        for (int i = 0; i < 8; i++) rnd_op(1'b1);
        repeat (ST) idle(1'b1);
        chk("b2b_count", 32'(n_emit - base), 32'(8));
        chk("b2b_drained", 32'(q.size()), 32'(0));

        // Capacity under a blocked output, then drain in order.
        chk_lat = 1'b0;
        base    = n_acc;
        repeat (4) rnd_op(1'b0);
        chk("cap_accepted", 32'(n_acc - base), 32'(ST));
        chk("cap_in_ready", 32'(in_ready), 32'(0));
        repeat (2) idle(1'b0);
        repeat (ST + 1) idle(1'b1);
        chk("cap_drained", 32'(q.size()), 32'(0));

        // Accept while full and emitting in the same cycle.
        repeat (2) rnd_op(1'b0);
        rnd_op(1'b1);
        repeat (ST + 1) idle(1'b1);
        chk("full_accept_drained", 32'(q.size()), 32'(0));

        // Reset with work in flight discards it.
        repeat (2) rnd_op(1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        q.delete();
        held = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_sum", 32'(out_sum), 32'(0));
        chk("mid_rst_flags", 32'({out_cout, out_ovf, out_zero}), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < ST + 2; i++) begin
            idle(1'b1);
            chk("no_stale", 32'(out_valid), 32'(0));
        end
        directed("post_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 3'b000);

        // Random traffic with random backpressure.
        chk_lat = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) rnd_op(1'($urandom_range(0, 3) != 0));
            else idle(1'($urandom_range(0, 3) != 0));
        end
        repeat (2 * ST + 2) idle(1'b1);
        chk("rand_drained", 32'(q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
